contrast_lut_stream: RTL and testbench

- Runtime-programmable 256-entry grey-level curve engine for the contrast path.
- Host/CPU side writes a curve into a shadow bank. A swap request promotes the shadow bank to active at the next frame start.
- The video side maps each 8-bit luma pixel through the active bank with a fixed 2-cycle pipeline.
- Replaces fixed compile-time curves; sits between the Y-extraction stage and downstream enhancement.

---
 rtl/contrast_lut_stream_pkg.sv | 14 +
 rtl/contrast_lut_stream_if.sv | 30 +++
 rtl/contrast_lut_stream_lut_dp_ram.sv | 23 ++
 rtl/contrast_lut_stream.sv | 123 ++++++++++++
 tb/tb_contrast_lut_stream.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/contrast_lut_stream_pkg.sv
// Shared widths and FSM encoding for the contrast curve engine.
package contrast_lut_stream_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned LUT_DEPTH = 256;
  localparam int unsigned LUT_AW    = 8;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StIdle = 2'd1,
    StPend = 2'd2
  } lut_state_e;

endpackage

// File: rtl/contrast_lut_stream_if.sv
// Host programming and video stream signals of the contrast curve engine.
interface contrast_lut_stream_if;
  import contrast_lut_stream_pkg::*;

  logic              lut_wr_en;
  logic [LUT_AW-1:0] lut_wr_addr;
  logic [DATA_W-1:0] lut_wr_data;
  logic              lut_swap_req;
  logic              lut_busy;
  logic              active_bank;
  logic              per_frame_vsync;
  logic              per_frame_href;
  logic [DATA_W-1:0] per_img_y;
  logic              post_frame_vsync;
  logic              post_frame_href;
  logic [DATA_W-1:0] post_img_y;

  modport master (
    output lut_wr_en, lut_wr_addr, lut_wr_data, lut_swap_req,
    output per_frame_vsync, per_frame_href, per_img_y,
    input  lut_busy, active_bank, post_frame_vsync, post_frame_href, post_img_y
  );

  modport slave (
    input  lut_wr_en, lut_wr_addr, lut_wr_data, lut_swap_req,
    input  per_frame_vsync, per_frame_href, per_img_y,
    output lut_busy, active_bank, post_frame_vsync, post_frame_href, post_img_y
  );

endinterface

// File: rtl/contrast_lut_stream_lut_dp_ram.sv
// 256x8 simple dual-port RAM: one write port, one registered read-first read port.
module contrast_lut_stream_lut_dp_ram
  import contrast_lut_stream_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [LUT_DEPTH];

  // No reset: contents are filled by the parent's INIT sweep.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/contrast_lut_stream.sv
// Double-buffered 256-entry luma curve with host-programmable shadow bank and
// a fixed 2-cycle lookup pipeline.
module contrast_lut_stream
  import contrast_lut_stream_pkg::*;
#(
  parameter int unsigned SYNC_SWAP = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  contrast_lut_stream_if.slave  bus
);

  lut_state_e        state_q;
  logic [LUT_AW-1:0] init_cnt_q;
  logic              active_bank_q, busy_q;
  logic              vsync_d1_q, href_d1_q, sel_d1_q;
  logic              post_vsync_q, post_href_q;
  logic [DATA_W-1:0] post_y_q;

  logic              init, host_we, vsync_rise, swap_now, rd_bank;
  logic              we0, we1;
  logic [LUT_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data, rdata0, rdata1, rdata;

  always_comb begin
    init       = (state_q == StInit);
    host_we    = bus.lut_wr_en && !init;
    // vsync_d1_q doubles as the registered previous vsync.
    vsync_rise = bus.per_frame_vsync && !vsync_d1_q;
    swap_now   = (SYNC_SWAP != 0) && (state_q == StPend) && vsync_rise;
    // The lookup issued on the swap cycle already reads the new bank.
    rd_bank    = active_bank_q ^ swap_now;
    // Host writes hit the pre-swap shadow, which is the new active bank on a swap edge.
    we0        = init || (host_we && active_bank_q);
    we1        = init || (host_we && !active_bank_q);
    wr_addr    = init ? init_cnt_q : bus.lut_wr_addr;
    wr_data    = init ? init_cnt_q : bus.lut_wr_data;
    rdata      = sel_d1_q ? rdata1 : rdata0;
  end

  contrast_lut_stream_lut_dp_ram u_bank0 (
    .clk   (clk),
    .we    (we0),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (bus.per_img_y),
    .rdata (rdata0)
  );

  contrast_lut_stream_lut_dp_ram u_bank1 (
    .clk   (clk),
    .we    (we1),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (bus.per_img_y),
    .rdata (rdata1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StInit;
      init_cnt_q    <= '0;
      active_bank_q <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LUT_AW'(LUT_DEPTH - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          if (bus.lut_swap_req) begin
            if (SYNC_SWAP != 0) begin
              state_q <= StPend;
              busy_q  <= 1'b1;
            end else begin
              active_bank_q <= !active_bank_q;
            end
          end
        end
        StPend: begin
          if (swap_now) begin
            state_q       <= StIdle;
            busy_q        <= 1'b0;
            active_bank_q <= !active_bank_q;
          end
        end
        default: begin
          state_q <= StInit;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d1_q   <= 1'b0;
      href_d1_q    <= 1'b0;
      sel_d1_q     <= 1'b0;
      post_vsync_q <= 1'b0;
      post_href_q  <= 1'b0;
      post_y_q     <= '0;
    end else begin
      vsync_d1_q   <= bus.per_frame_vsync;
      href_d1_q    <= bus.per_frame_href;
      sel_d1_q     <= rd_bank;
      post_vsync_q <= vsync_d1_q;
      post_href_q  <= href_d1_q;
      post_y_q     <= href_d1_q ? rdata : '0;
    end
  end

  assign bus.lut_busy         = busy_q;
  assign bus.active_bank      = active_bank_q;
  assign bus.post_frame_vsync = post_vsync_q;
  assign bus.post_frame_href  = post_href_q;
  assign bus.post_img_y       = post_y_q;

endmodule

// File: tb/tb_contrast_lut_stream.sv
// Scoreboard bench for contrast_lut_stream (synchronous-swap and immediate-swap builds).
module tb_contrast_lut_stream;
  import contrast_lut_stream_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  contrast_lut_stream_if bus ();
  contrast_lut_stream_if bus2 ();

  contrast_lut_stream #(.SYNC_SWAP(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  contrast_lut_stream #(.SYNC_SWAP(0)) u_dut_async (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of the curve banks and swap control (0=INIT, 1=IDLE, 2=PEND).
  logic [7:0] m_bank [2][256];
  bit         m_act;
  int         m_state;
  bit         m_prev_vs;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;

  task automatic model_reset();
    for (int a = 0; a < 256; a++) begin
      m_bank[0][a] = 8'(a);
      m_bank[1][a] = 8'(a);
    end
    m_act     = 1'b0;
    m_state   = 0;
    m_prev_vs = 1'b0;
    exp_q.delete();
  endtask

  // One full clock of stimulus on the synchronous-swap DUT, then control checks.
  task automatic cyc(input bit vs, input bit hs, input logic [7:0] y, input bit req,
                     input bit we, input logic [7:0] wa, input logic [7:0] wd);
    bit rise, old_act;
    int old_state;
    @(negedge clk);
    bus.per_frame_vsync = vs;
    bus.per_frame_href  = hs;
    bus.per_img_y       = y;
    bus.lut_swap_req    = req;
    bus.lut_wr_en       = we;
    bus.lut_wr_addr     = wa;
    bus.lut_wr_data     = wd;
    rise      = vs && !m_prev_vs;
    m_prev_vs = vs;
    old_act   = m_act;
    old_state = m_state;
    if (old_state == 2 && rise) begin
      m_act   = !m_act;
      m_state = 1;
    end
    if (hs) exp_q.push_back(m_bank[m_act][y]);
    if (we && old_state != 0) m_bank[!old_act][wa] = wd;
    if (old_state == 1 && req) m_state = 2;
    @(posedge clk);
    #1;
    check_eq("lut_busy", bus.lut_busy, 32'(m_state != 1));
    check_eq("active_bank", bus.active_bank, 32'(m_act));
  endtask

  task automatic idle(input int n, input bit vs);
    for (int i = 0; i < n; i++) cyc(vs, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check_eq("drain", exp_q.size(), 0);
  endtask

  // Releases reset and measures how long the INIT sweep keeps lut_busy high.
  task automatic wait_init();
    int n;
    n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 8) begin
        bus.lut_wr_en    = 1'b0;
        bus.lut_swap_req = 1'b0;
      end
      if (!bus.lut_busy) break;
    end
    check_eq("init_cycles", n, 256);
    check_eq("init_active_bank", bus.active_bank, 0);
    m_state = 1;
    mon_en  = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (bus.post_frame_href) begin
        if (exp_q.size() == 0) check_eq("pixel_expected", exp_q.size(), 1);
        else check_eq("post_img_y", bus.post_img_y, exp_q.pop_front());
      end else begin
        check_eq("post_img_y_blank", bus.post_img_y, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    {bus.lut_wr_en, bus.lut_swap_req, bus.per_frame_vsync, bus.per_frame_href} = '0;
    bus.lut_wr_addr = '0; bus.lut_wr_data = '0; bus.per_img_y = '0;
    {bus2.lut_wr_en, bus2.lut_swap_req, bus2.per_frame_vsync, bus2.per_frame_href} = '0;
    bus2.lut_wr_addr = '0; bus2.lut_wr_data = '0; bus2.per_img_y = '0;
    model_reset();

    // Reset with a host write and swap request held; both must be ignored by INIT.
    bus.lut_wr_en    = 1'b1;
    bus.lut_wr_addr  = 8'h40;
    bus.lut_wr_data  = 8'h55;
    bus.lut_swap_req = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", bus.lut_busy, 1);
    check_eq("rst_active_bank", bus.active_bank, 0);
    check_eq("rst_post_href", bus.post_frame_href, 0);
    check_eq("rst_post_vsync", bus.post_frame_vsync, 0);
    check_eq("rst_post_img_y", bus.post_img_y, 0);
    wait_init();

    // Identity curve after INIT.
    cyc(0, 1, 8'h00, 0, 0, 0, 0);
    cyc(0, 1, 8'h7F, 0, 0, 0, 0);
    cyc(0, 1, 8'hFF, 0, 0, 0, 0);
    idle(1, 0);
    drain();

    // Promote bank1: address 0x40 must still be identity.
    cyc(0, 0, 8'h00, 1, 0, 0, 0);
    idle(2, 0);
    idle(1, 1);
    idle(1, 0);
    cyc(0, 1, 8'h40, 0, 0, 0, 0);
    idle(1, 0);
    drain();

    // Load inverse curve into shadow, request swap mid-frame, collide a write with the edge.
    for (int a = 0; a < 256; a++) cyc(0, 0, 8'h00, 0, 1, 8'(a), 8'(8'hFF - a));
    idle(1, 1);
    idle(1, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 8'(i * 20), i == 3, 0, 0, 0);
    idle(1, 0);
    cyc(1, 1, 8'h20, 0, 1, 8'h20, 8'h99);
    cyc(1, 1, 8'h10, 0, 0, 0, 0);
    cyc(0, 1, 8'h20, 0, 0, 0, 0);
    idle(1, 0);
    drain();

    // Request on the very cycle vsync rises waits for the next rise.
    cyc(1, 0, 8'h00, 1, 0, 0, 0);
    cyc(1, 1, 8'h10, 0, 0, 0, 0);
    idle(2, 0);
    cyc(1, 1, 8'h10, 0, 0, 0, 0);
    idle(1, 0);
    drain();

    // Reset while a loaded curve is pending.
    for (int a = 0; a < 16; a++) cyc(0, 0, 8'h00, 0, 1, 8'(a), 8'(a ^ 8'hA5));
    cyc(0, 1, 8'h03, 1, 0, 0, 0);
    cyc(0, 1, 8'h04, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    mon_en = 1'b0;
    #1;
    check_eq("midrst_post_href", bus.post_frame_href, 0);
    check_eq("midrst_post_img_y", bus.post_img_y, 0);
    check_eq("midrst_busy", bus.lut_busy, 1);
    check_eq("midrst_active_bank", bus.active_bank, 0);
    model_reset();
    bus.per_frame_href = 1'b0;
    bus.lut_swap_req   = 1'b0;
    bus.lut_wr_en      = 1'b0;
    repeat (2) @(negedge clk);
    wait_init();
    cyc(0, 1, 8'h03, 0, 0, 0, 0);
    cyc(0, 1, 8'hC3, 0, 0, 0, 0);
    idle(1, 0);
    drain();

    // Immediate-swap build: toggle the cycle after the request, new bank for the next pixel.
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      bus2.lut_wr_en   = 1'b1;
      bus2.lut_wr_addr = 8'(a);
      bus2.lut_wr_data = 8'(8'hFF - a);
    end
    @(negedge clk);
    bus2.lut_wr_en = 1'b0;
    check_eq("async_bank_before", bus2.active_bank, 0);
    bus2.lut_swap_req = 1'b1;
    @(posedge clk);
    #1;
    check_eq("async_bank_toggle", bus2.active_bank, 1);
    check_eq("async_busy", bus2.lut_busy, 0);
    @(negedge clk);
    bus2.lut_swap_req   = 1'b0;
    bus2.per_frame_href = 1'b1;
    bus2.per_img_y      = 8'h10;
    @(negedge clk);
    bus2.per_frame_href = 1'b0;
    @(posedge clk);
    #1;
    check_eq("async_post_href", bus2.post_frame_href, 1);
    check_eq("async_post_img_y", bus2.post_img_y, 32'h00EF);
    @(posedge clk);
    #1;
    check_eq("async_post_href_end", bus2.post_frame_href, 0);
    check_eq("async_bank_hold", bus2.active_bank, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
